// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: counts newly-set enabled status bits and raises one
// irq when the count reaches a threshold or a holdoff timer expires.
module rggen_irq_coalescer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TIMER_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_status,
  input  logic [WIDTH-1:0]       i_enable,
  input  logic [COUNT_WIDTH-1:0] i_threshold,
  input  logic [TIMER_WIDTH-1:0] i_timeout,
  input  logic                   i_ack,
  output logic                   o_irq,
  output logic [COUNT_WIDTH-1:0] o_event_count,
  output logic                   o_busy
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = COUNT_WIDTH + POP_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] ASSERT  = 2'd2;

  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({COUNT_WIDTH{1'b1}});

  logic [1:0]             state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]       prev_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   irq_d;

  logic [WIDTH-1:0]       masked_c;
  logic [WIDTH-1:0]       rise_c;
  logic [POP_W-1:0]       n_rise_c;
  logic [SUM_W-1:0]       sum_c;
  logic [COUNT_WIDTH-1:0] count_next_c;
  logic [COUNT_WIDTH-1:0] rise_sat_c;
  logic [COUNT_WIDTH-1:0] thr_c;
  logic                   hit_c;

  // Edge detection, popcount and saturating event arithmetic.
  always_comb begin
    masked_c = i_status & i_enable;
    rise_c   = masked_c & ~prev_q;
    n_rise_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n_rise_c = n_rise_c + POP_W'(rise_c[i]);
    end
    sum_c        = SUM_W'(o_event_count) + SUM_W'(n_rise_c);
    count_next_c = (sum_c > CNT_MAX) ? {COUNT_WIDTH{1'b1}} : COUNT_WIDTH'(sum_c);
    rise_sat_c   = (SUM_W'(n_rise_c) > CNT_MAX) ? {COUNT_WIDTH{1'b1}}
                                                 : COUNT_WIDTH'(n_rise_c);
    thr_c        = (i_threshold == '0) ? COUNT_WIDTH'(1) : i_threshold;
    hit_c        = (count_next_c >= thr_c);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = o_event_count;
    irq_d   = o_irq;
    unique case (state_q)
      IDLE: begin
        if (n_rise_c != '0) begin
          count_d = count_next_c;
          if (hit_c) begin
            state_d = ASSERT;
            irq_d   = 1'b1;
          end else begin
            state_d = COLLECT;
            timer_d = i_timeout;
          end
        end
      end
      COLLECT: begin
        if (masked_c == '0) begin
          // status withdrawn before firing: drop the batch silently
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_next_c;
          if (hit_c || (timer_q == '0)) begin
            state_d = ASSERT;
            irq_d   = 1'b1;
          end else begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end
        end
      end
      ASSERT: begin
        if (i_ack || (masked_c == '0)) begin
          irq_d = 1'b0;
          if (n_rise_c != '0) begin
            // an edge arriving with the ack opens a fresh batch
            state_d = COLLECT;
            count_d = rise_sat_c;
            timer_d = i_timeout;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else begin
          count_d = count_next_c;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        irq_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      prev_q        <= '0;
      o_event_count <= '0;
      o_irq         <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      prev_q        <= masked_c;
      o_event_count <= count_d;
      o_irq         <= irq_d;
      o_busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Self-checking bench: two coalescers (8-bit and 2-bit counters) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_rggen_irq_coalescer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  status;
  logic [7:0]  enable;
  logic [7:0]  thr;
  logic [1:0]  thr_b;
  logic [15:0] tmo;
  logic        ack;

  logic        irq_a, busy_a, irq_b, busy_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int vectors    = 0;
  int miscompares = 0;
  bit checking   = 1'b0;
  longint cyc    = 0;

  assign thr_b = thr[1:0];

  always #5 clk = ~clk;

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(8), .TIMER_WIDTH(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_status(status), .i_enable(enable),
    .i_threshold(thr), .i_timeout(tmo), .i_ack(ack),
    .o_irq(irq_a), .o_event_count(cnt_a), .o_busy(busy_a)
  );

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(16)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_status(status), .i_enable(enable),
    .i_threshold(thr_b), .i_timeout(tmo), .i_ack(ack),
    .o_irq(irq_b), .o_event_count(cnt_b), .o_busy(busy_b)
  );

  // Model view: busy means a batch is open, irq means it has fired;
  // the holdoff is an absolute edge index rather than a down-counter.
  typedef struct {
    int       cnt;
    bit       irq;
    bit       busy;
    bit [7:0] prev;
    longint   deadline;
  } model_t;

  model_t m_a, m_b;

  function automatic model_t step(model_t m, bit r, bit [7:0] st, bit [7:0] en,
                                  int th, int to, bit ak, int maxc, longint now);
    model_t   n;
    bit [7:0] masked;
    int       nr, sum, t;
    n = m;
    if (r) begin
      n.cnt = 0; n.irq = 0; n.busy = 0; n.prev = '0; n.deadline = 0;
      return n;
    end
    masked = st & en;
    nr     = $countones(masked & ~m.prev);
    sum    = (m.cnt + nr > maxc) ? maxc : m.cnt + nr;
    t      = (th == 0) ? 1 : th;
    if (!m.busy) begin
      if (nr > 0) begin
        n.cnt  = sum;
        n.busy = 1;
        if (sum >= t) n.irq = 1;
        else          n.deadline = now + to + 1;
      end
    end else if (!m.irq) begin
      if (masked == 0) begin
        n.busy = 0; n.cnt = 0;
      end else begin
        n.cnt = sum;
        if (sum >= t || now >= m.deadline) n.irq = 1;
      end
    end else begin
      if (ak || masked == 0) begin
        n.irq = 0;
        if (nr > 0) begin
          n.cnt      = (nr > maxc) ? maxc : nr;
          n.deadline = now + to + 1;
        end else begin
          n.busy = 0; n.cnt = 0;
        end
      end else begin
        n.cnt = sum;
      end
    end
    n.prev = masked;
    return n;
  endfunction

  // Advance both models on every active edge from the inputs at that edge.
  always @(posedge clk) begin
    m_a = step(m_a, rst, status, enable, int'(thr),   int'(tmo), ack, 255, cyc);
    m_b = step(m_b, rst, status, enable, int'(thr_b), int'(tmo), ack, 3,   cyc);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both DUTs against the model, away from the edge.
  always @(negedge clk) begin
    if (checking) begin
      check("a_irq",   int'(irq_a),  int'(m_a.irq));
      check("a_count", int'(cnt_a),  m_a.cnt);
      check("a_busy",  int'(busy_a), int'(m_a.busy));
      check("b_irq",   int'(irq_b),  int'(m_b.irq));
      check("b_count", int'(cnt_b),  m_b.cnt);
      check("b_busy",  int'(busy_b), int'(m_b.busy));
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; status = 0; enable = 0; thr = 1; tmo = 100; ack = 0;
    cyc_n(2);
    rst = 0;
    checking = 1'b1;
    check("reset_irq",   int'(irq_a),  0);
    check("reset_count", int'(cnt_a),  0);
    check("reset_busy",  int'(busy_a), 0);

    // threshold 1: immediate irq, ack returns to idle
    enable = 8'hFF; thr = 1; tmo = 100;
    status = 8'h08; cyc_n(1);
    check("thr1_irq",   int'(irq_a), 1);
    check("thr1_count", int'(cnt_a), 1);
    ack = 1; cyc_n(1); ack = 0;
    check("thr1_ack_irq",   int'(irq_a),  0);
    check("thr1_ack_count", int'(cnt_a),  0);
    check("thr1_ack_busy",  int'(busy_a), 0);
    status = 0; cyc_n(2);

    // count threshold 4 reached on second batch of edges
    thr = 4; tmo = 1000;
    status = 8'h03; cyc_n(3);
    check("cnt4_pre_irq",   int'(irq_a), 0);
    check("cnt4_pre_count", int'(cnt_a), 2);
    status = 8'h27; cyc_n(1);
    check("cnt4_irq",   int'(irq_a), 1);
    check("cnt4_count", int'(cnt_a), 4);
    status = 0; cyc_n(2);

    // holdoff timeout 3 (ack in COLLECT ignored), then timeout 0
    thr = 10; tmo = 3;
    status = 8'h01; cyc_n(1);
    ack = 1; cyc_n(1); ack = 0;
    cyc_n(2);
    check("to3_early_irq", int'(irq_a), 0);
    cyc_n(1);
    check("to3_irq",   int'(irq_a), 1);
    check("to3_count", int'(cnt_a), 1);
    status = 0; cyc_n(2);
    tmo = 0;
    status = 8'h01; cyc_n(1);
    check("to0_early_irq", int'(irq_a), 0);
    cyc_n(1);
    check("to0_irq", int'(irq_a), 1);
    status = 0; cyc_n(2);

    // masked bit, late enable counts as a rise, cancel in COLLECT
    tmo = 1000; enable = 8'hFB;
    status = 8'h04; cyc_n(3);
    check("mask_irq",   int'(irq_a), 0);
    check("mask_count", int'(cnt_a), 0);
    enable = 8'hFF; cyc_n(1);
    check("unmask_count", int'(cnt_a),  1);
    check("unmask_busy",  int'(busy_a), 1);
    status = 0; cyc_n(1);
    check("cancel_busy",  int'(busy_a), 0);
    check("cancel_count", int'(cnt_a),  0);
    cyc_n(3);
    check("cancel_irq", int'(irq_a), 0);

    // all bits at once: 2-bit counter saturates at 3
    thr = 3;
    status = 8'hFF; cyc_n(1);
    check("sat_a_count", int'(cnt_a), 8);
    check("sat_b_count", int'(cnt_b), 3);
    check("sat_b_irq",   int'(irq_b), 1);
    status = 0; cyc_n(2);

    // accumulate in ASSERT, then ack coinciding with a new edge
    thr = 1;
    status = 8'h01; cyc_n(1);
    status = 8'h03; cyc_n(1);
    check("acc_count", int'(cnt_a), 2);
    ack = 1; status = 8'h07; cyc_n(1); ack = 0;
    check("ackrise_irq",   int'(irq_a),  0);
    check("ackrise_count", int'(cnt_a),  1);
    check("ackrise_busy",  int'(busy_a), 1);
    cyc_n(1);
    check("ackrise_refire", int'(irq_a), 1);
    status = 0; cyc_n(2);

    // reset in COLLECT aborts the batch
    thr = 10; tmo = 1000;
    status = 8'h01; cyc_n(2);
    status = 8'h03; cyc_n(1);
    check("prerst_count", int'(cnt_a), 2);
    rst = 1; cyc_n(1); rst = 0;
    check("rst_irq",   int'(irq_a),  0);
    check("rst_count", int'(cnt_a),  0);
    check("rst_busy",  int'(busy_a), 0);
    cyc_n(20);
    check("postrst_irq", int'(irq_a), 0);

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
